// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is whoever drives it.
interface instruction_fetch_stage_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
);
    logic               i_start;
    logic               i_enable;
    logic               i_stall;
    logic               i_flush;
    logic [NB_ADDR-1:0] i_branch_target;
    logic [NB_DATA-1:0] i_imem_data;
    logic [NB_ADDR-1:0] o_imem_addr;
    logic [NB_DATA-1:0] o_IF_ID_instr;
    logic [NB_ADDR-1:0] o_IF_ID_pc_plus4;
    logic               o_IF_ID_valid;
    logic               o_halted;
    logic [31:0]        o_fetch_count;

    modport slave (
        input  i_start, i_enable, i_stall, i_flush, i_branch_target, i_imem_data,
        output o_imem_addr, o_IF_ID_instr, o_IF_ID_pc_plus4, o_IF_ID_valid,
               o_halted, o_fetch_count
    );

    modport master (
        output i_start, i_enable, i_stall, i_flush, i_branch_target, i_imem_data,
        input  o_imem_addr, o_IF_ID_instr, o_IF_ID_pc_plus4, o_IF_ID_valid,
               o_halted, o_fetch_count
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC register, IF/ID pipeline register, IDLE/RUN/HALTED control
// and a saturating count of instructions captured into IF/ID.
module instruction_fetch_stage #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 32,
    parameter logic [NB_ADDR-1:0] RESET_PC  = '0,
    parameter logic [NB_DATA-1:0] HALT_WORD = '1,
    parameter logic [NB_DATA-1:0] NOP_WORD  = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    instruction_fetch_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [NB_ADDR-1:0] PC_STEP    = NB_ADDR'(4);
    localparam logic [NB_ADDR-1:0] ALIGN_MASK = ~NB_ADDR'(3);

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_ADDR-1:0] pcp4_q, pcp4_d;
    logic               valid_q, valid_d;
    logic [31:0]        count_q, count_d;

    logic [NB_ADDR-1:0] pc_plus4;
    logic [NB_ADDR-1:0] target_aligned;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign pc_plus4       = pc_q + PC_STEP;
    assign target_aligned = bus.i_branch_target & ALIGN_MASK;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                pc_d    = RESET_PC;
                instr_d = NOP_WORD;
                pcp4_d  = '0;
                valid_d = 1'b0;
                if (bus.i_start) state_d = RUN;
            end

            RUN: begin
                if (bus.i_enable) begin
                    if (bus.i_flush) begin
                        pc_d    = target_aligned;
                        instr_d = NOP_WORD;
                        pcp4_d  = '0;
                        valid_d = 1'b0;
                    end else if (!bus.i_stall) begin
                        instr_d = bus.i_imem_data;
                        pcp4_d  = pc_plus4;
                        valid_d = 1'b1;
                        count_d = sat_inc(count_q);
                        // A captured halt word parks the PC on itself.
                        if (bus.i_imem_data == HALT_WORD) state_d = HALTED;
                        else                              pc_d    = pc_plus4;
                    end
                end
            end

            HALTED: begin
                if (bus.i_enable) begin
                    if (bus.i_flush) begin
                        // Halt was on the wrong path of a taken branch.
                        pc_d    = target_aligned;
                        instr_d = NOP_WORD;
                        pcp4_d  = '0;
                        valid_d = 1'b0;
                        state_d = RUN;
                    end else if (!bus.i_stall) begin
                        instr_d = NOP_WORD;
                        pcp4_d  = '0;
                        valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                pc_d    = RESET_PC;
                instr_d = NOP_WORD;
                pcp4_d  = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.o_imem_addr      = pc_q;
    assign bus.o_IF_ID_instr    = instr_q;
    assign bus.o_IF_ID_pc_plus4 = pcp4_q;
    assign bus.o_IF_ID_valid    = valid_q;
    assign bus.o_halted         = (state_q == HALTED);
    assign bus.o_fetch_count    = count_q;

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Front end of the 5-stage MIPS pipeline. It owns the PC register and the IF/ID pipeline register, and consumes the load-use stall produced by the hazard detection unit and the branch/jump redirect resolved in ID. It drives the instruction-memory address and captures the fetched word for the decode stage. A small state machine handles start, run and halt, and a fetch counter serves the debug unit.

Parameters:
NB_DATA, 32, instruction word width
NB_ADDR, 32, PC / instruction-memory byte address width
RESET_PC, 0, PC value after reset and in IDLE
HALT_WORD, 32'hFFFFFFFF, instruction encoding that halts fetch
NOP_WORD, 32'h00000000, bubble inserted into IF/ID

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  leave IDLE and begin fetching
i_enable  in  1  pipeline advance enable (debug step/run); 0 freezes block
i_stall  in  1  load-use stall from hazard detection unit
i_flush  in  1  taken branch/jump resolved in ID
i_branch_target  in  NB_ADDR  redirect address, valid with i_flush
i_imem_data  in  NB_DATA  instruction at o_imem_addr, combinational read
o_imem_addr  out  NB_ADDR  fetch address, equal to PC
o_IF_ID_instr  out  NB_DATA  instruction to ID
o_IF_ID_pc_plus4  out  NB_ADDR  PC+4 of that instruction
o_IF_ID_valid  out  1  1 = real instruction, 0 = bubble
o_halted  out  1  state is HALTED
o_fetch_count  out  32  instructions captured into IF/ID

Behaviour:
- Reset (async assert, sync release): state=IDLE, PC=RESET_PC, o_IF_ID_instr=NOP_WORD, o_IF_ID_pc_plus4=0, o_IF_ID_valid=0, o_halted=0, o_fetch_count=0. Reset mid-operation aborts everything immediately.
- o_imem_addr = PC combinationally. o_halted = (state==HALTED) combinationally.
- IDLE: PC held at RESET_PC; IF/ID holds a bubble. i_start=1 gives RUN next edge, independent of i_enable. The first capture happens on the following enabled edge.
- i_enable=0 in RUN or HALTED: PC, IF/ID, state and counter all hold. i_stall and i_flush are ignored that cycle.
- RUN, i_enable=1, priority flush > stall > advance:
  - flush: PC<=i_branch_target with bits[1:0] forced to 0. IF/ID<=bubble (NOP_WORD, valid=0, pc_plus4=0). Counter unchanged. Flush overrides a simultaneous stall.
  - stall, no flush: PC and IF/ID hold their values. Counter unchanged.
  - advance: IF/ID<={i_imem_data, PC+4, valid=1}. Counter +1, saturating at 2^32-1.
    - If i_imem_data==HALT_WORD: the halt word is captured, PC holds (not incremented), state->HALTED.
    - Otherwise PC<=PC+4.
- PC+4 wraps modulo 2^NB_ADDR, so 0xFFFFFFFC advances to 0x00000000.
- HALTED, i_enable=1:
  - No flush: IF/ID<=bubble each edge, so the halt word enters ID exactly once. PC holds.
  - i_flush=1: the halt was wrong-path. PC<=target, IF/ID<=bubble, state->RUN.
  - i_stall=1 with no flush: IF/ID holds, so the halt word stays in ID while the stall lasts.
- HALTED, i_start has no effect; only a flush or reset leaves HALTED.
- Stall never suppresses halt detection on a later cycle. Detection happens only on an advance edge.
- State encoding: IDLE, RUN, HALTED. An unused encoding returns to IDLE.

Test Plan:
- Reset, i_start, enable=1, imem returns 0x20010005 at 0, 0x20020007 at 4 -> IF/ID gets (0x20010005, pc_plus4=4, valid=1) then (0x20020007, 8, 1); o_imem_addr steps 0,4,8; count=2.
- i_stall=1 for 2 cycles at PC=8 -> PC stays 8; IF/ID holds the prior word for 2 cycles; count unchanged; resumes at PC=8 on release.
- i_flush=1 with i_stall=1 and target=0x43 at PC=0x10 -> next PC=0x40; IF/ID=bubble (valid=0, NOP); then fetch at 0x40 gives pc_plus4=0x44.
- HALT_WORD at PC=0x0C -> IF/ID holds halt for 1 cycle with valid=1, then bubbles; PC stays 0x0C; o_halted=1; i_start ignored. A later flush to 0x20 clears o_halted and fetches 0x20.
- i_enable=0 for 3 cycles mid-run, with i_flush pulsed during the freeze -> no change to PC, IF/ID, state or counter; flush is lost.
- i_rst_n asserted asynchronously mid-cycle while RUN at PC=0x30 -> outputs immediately take reset values; after release block stays IDLE until i_start.
